// File: rtl/pipeline_sequencer.sv
// Central sequencer for the 5-stage in-order core (fetch, decode, exec, mem, write).
// Owns the PC and issues per-stage enable pulses, flush levels and the load
// strobes for the four inter-stage registers. It inserts a one-cycle bubble for
// load-use hazards and squashes fetch/decode on taken jumps. Every output comes
// straight from a register.
module pipeline_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_stage_done,
  input  logic             i_load_use,
  input  logic             i_jump_taken,
  input  logic [31:0]      i_jump_dest,
  output logic [31:0]      o_pc,
  output logic [4:0]       o_stage_en,
  output logic [4:0]       o_stage_flush,
  output logic [3:0]       o_latch,
  output logic             o_stalling,
  output logic [CNT_W-1:0] o_retired
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_nxt;
  logic [4:0]         r_en;
  logic [4:0]         w_en_nxt;
  logic [4:0]         r_flush;
  logic [4:0]         w_flush_nxt;
  logic [3:0]         r_latch;
  logic [3:0]         w_latch_nxt;
  logic [CNT_W-1:0]   r_retired;
  logic [CNT_W-1:0]   w_retired_nxt;

  // A stage's result only counts if that stage was holding a live instruction.
  logic [4:0]         w_avail;
  logic               w_all_done;
  logic [CNT_W-1:0]   w_ret_inc;

  assign w_avail    = i_stage_done & ~r_flush;
  assign w_all_done = &(r_flush | i_stage_done);
  assign w_ret_inc  = {{(CNT_W-1){1'b0}}, w_avail[4]};

  // Next-state and next-output decode; holds everything except strobes until all live stages finish.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_en_nxt      = 5'b00000;
    w_flush_nxt   = r_flush;
    w_latch_nxt   = 4'b0000;
    w_retired_nxt = r_retired;
    if (w_all_done) begin
      // Back half of the pipe always shifts on an advance, whichever front-end case applies.
      w_en_nxt[4:3]    = w_avail[3:2];
      w_flush_nxt[4:3] = ~w_avail[3:2];
      w_latch_nxt[3:2] = 2'b11;
      w_retired_nxt    = r_retired + w_ret_inc;
      case (r_state)
        ST_STALL: begin
          // Bubble done: release the held fetch word and re-run the front end.
          w_state_nxt      = ST_RUN;
          w_pc_nxt         = r_pc + 32'd4;
          w_en_nxt[2:0]    = 3'b111;
          w_flush_nxt[2:0] = 3'b000;
          w_latch_nxt[1:0] = 2'b11;
        end
        ST_RUN: begin
          if (i_load_use && w_avail[2]) begin
            // Keep the fetched word, re-decode with forwarding, bubble into exec.
            w_state_nxt      = ST_STALL;
            w_pc_nxt         = r_pc;
            w_en_nxt[2:0]    = 3'b010;
            w_flush_nxt[2:0] = 3'b100;
            w_latch_nxt[1:0] = 2'b00;
          end else if (i_jump_taken && w_avail[2]) begin
            // Redirect fetch; the two younger slots are wrong-path and get squashed.
            w_state_nxt      = ST_RUN;
            w_pc_nxt         = i_jump_dest;
            w_en_nxt[2:0]    = 3'b001;
            w_flush_nxt[2:0] = 3'b110;
            w_latch_nxt[1:0] = 2'b00;
          end else begin
            // Plain advance: live fetch/decode results move one stage down.
            w_state_nxt      = ST_RUN;
            w_pc_nxt         = r_pc + 32'd4;
            w_en_nxt[2:0]    = {w_avail[1:0], 1'b1};
            w_flush_nxt[2:0] = {~w_avail[1:0], 1'b0};
            w_latch_nxt[1:0] = 2'b11;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end else begin
      // Some live stage still busy: no pulses, no strobes, state frozen.
      w_en_nxt    = 5'b00000;
      w_latch_nxt = 4'b0000;
    end
  end

  // State and output registers with synchronous reset to the post-reset fetch pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_en      <= 5'b00001;
      r_flush   <= 5'b11110;
      r_latch   <= 4'b0000;
      r_retired <= {CNT_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_en      <= w_en_nxt;
      r_flush   <= w_flush_nxt;
      r_latch   <= w_latch_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  assign o_pc          = r_pc;
  assign o_stage_en    = r_en;
  assign o_stage_flush = r_flush;
  assign o_latch       = r_latch;
  assign o_stalling    = (r_state == ST_STALL);
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: each directed step pushes the
// hand-computed register state expected after the next clock edge; a monitor
// pops and compares after every edge.
module tb_pipeline_sequencer;

  logic        clk;
  logic        rst;
  logic [4:0]  stage_done;
  logic        load_use;
  logic        jump_taken;
  logic [31:0] jump_dest;
  logic [31:0] pc;
  logic [4:0]  stage_en;
  logic [4:0]  stage_flush;
  logic [3:0]  latch;
  logic        stalling;
  logic [63:0] retired;

  pipeline_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(64)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stage_done (stage_done),
    .i_load_use   (load_use),
    .i_jump_taken (jump_taken),
    .i_jump_dest  (jump_dest),
    .o_pc         (pc),
    .o_stage_en   (stage_en),
    .o_stage_flush(stage_flush),
    .o_latch      (latch),
    .o_stalling   (stalling),
    .o_retired    (retired)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  en;
    logic [4:0]  fl;
    logic [3:0]  la;
    logic        st;
    logic [63:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_step = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int step, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s (check %0d): got %0h, expected %0h", name, step, act, want);
    end
  endtask

  // Monitor: one expected state per clock edge once stimulus has queued it
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_step++;
      chk("pc",       n_step, {32'd0, pc},          {32'd0, e.pc});
      chk("stage_en", n_step, {59'd0, stage_en},    {59'd0, e.en});
      chk("flush",    n_step, {59'd0, stage_flush}, {59'd0, e.fl});
      chk("latch",    n_step, {60'd0, latch},       {60'd0, e.la});
      chk("stalling", n_step, {63'd0, stalling},    {63'd0, e.st});
      chk("retired",  n_step, retired,              e.ret);
    end
  end

  task automatic step(input logic r, input logic [4:0] d, input logic lu, input logic jt,
                      input logic [31:0] jd, input logic [31:0] e_pc, input logic [4:0] e_en,
                      input logic [4:0] e_fl, input logic [3:0] e_la, input logic e_st,
                      input logic [63:0] e_ret);
    exp_t e;
    @(negedge clk);
    rst        = r;
    stage_done = d;
    load_use   = lu;
    jump_taken = jt;
    jump_dest  = jd;
    e.pc  = e_pc;
    e.en  = e_en;
    e.fl  = e_fl;
    e.la  = e_la;
    e.st  = e_st;
    e.ret = e_ret;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; stage_done = 5'b00000; load_use = 1'b0; jump_taken = 1'b0; jump_dest = 32'h0;
    //    rst   done      lu    jt    dest           pc             en        flush     latch    st    retired
    step(1'b1, 5'b10101, 1'b1, 1'b1, 32'h0000_1234, 32'h0000_0000, 5'b00001, 5'b11110, 4'b0000, 1'b0, 64'd0);
    // Pipeline fill
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0004, 5'b00011, 5'b11100, 4'b1111, 1'b0, 64'd0);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0008, 5'b00111, 5'b11000, 4'b1111, 1'b0, 64'd0);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_000C, 5'b01111, 5'b10000, 4'b1111, 1'b0, 64'd0);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0010, 5'b11111, 5'b00000, 4'b1111, 1'b0, 64'd0);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0014, 5'b11111, 5'b00000, 4'b1111, 1'b0, 64'd1);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0018, 5'b11111, 5'b00000, 4'b1111, 1'b0, 64'd2);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_001C, 5'b11111, 5'b00000, 4'b1111, 1'b0, 64'd3);
    // mem busy for 3 cycles: hold
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'b10111, 1'b0, 1'b0, 32'h0,       32'h0000_001C, 5'b00000, 5'b00000, 4'b0000, 1'b0, 64'd3);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0020, 5'b11111, 5'b00000, 4'b1111, 1'b0, 64'd4);
    // Load-use at pc 0x20, then stall release (load_use during stall ignored)
    step(1'b0, 5'b11111, 1'b1, 1'b0, 32'h0,         32'h0000_0020, 5'b11010, 5'b00100, 4'b1100, 1'b1, 64'd5);
    step(1'b0, 5'b11111, 1'b1, 1'b0, 32'h0,         32'h0000_0024, 5'b10111, 5'b01000, 4'b1111, 1'b0, 64'd6);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0028, 5'b01111, 5'b10000, 4'b1111, 1'b0, 64'd7);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_002C, 5'b11111, 5'b00000, 4'b1111, 1'b0, 64'd7);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0030, 5'b11111, 5'b00000, 4'b1111, 1'b0, 64'd8);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0034, 5'b11111, 5'b00000, 4'b1111, 1'b0, 64'd9);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0038, 5'b11111, 5'b00000, 4'b1111, 1'b0, 64'd10);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_003C, 5'b11111, 5'b00000, 4'b1111, 1'b0, 64'd11);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0040, 5'b11111, 5'b00000, 4'b1111, 1'b0, 64'd12);
    // Jump at pc 0x40 to 0x100
    step(1'b0, 5'b11111, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100, 5'b11001, 5'b00110, 4'b1100, 1'b0, 64'd13);
    // exec flushed: jump and load_use ignored
    step(1'b0, 5'b11111, 1'b1, 1'b1, 32'hDEAD_0000, 32'h0000_0104, 5'b10011, 5'b01100, 4'b1111, 1'b0, 64'd14);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0108, 5'b00111, 5'b11000, 4'b1111, 1'b0, 64'd15);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_010C, 5'b01111, 5'b10000, 4'b1111, 1'b0, 64'd15);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0110, 5'b11111, 5'b00000, 4'b1111, 1'b0, 64'd15);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0114, 5'b11111, 5'b00000, 4'b1111, 1'b0, 64'd16);
    // load_use and jump together: bubble wins, jump re-resolved later
    step(1'b0, 5'b11111, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0114, 5'b11010, 5'b00100, 4'b1100, 1'b1, 64'd17);
    step(1'b0, 5'b11111, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0118, 5'b10111, 5'b01000, 4'b1111, 1'b0, 64'd18);
    step(1'b0, 5'b11111, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0200, 5'b01001, 5'b10110, 4'b1100, 1'b0, 64'd19);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0204, 5'b10011, 5'b01100, 4'b1111, 1'b0, 64'd19);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0208, 5'b00111, 5'b11000, 4'b1111, 1'b0, 64'd20);
    // Jump to top of address space, then pc wraps to 0
    step(1'b0, 5'b11111, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 5'b01001, 5'b10110, 4'b1100, 1'b0, 64'd20);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0000, 5'b10011, 5'b01100, 4'b1111, 1'b0, 64'd20);
    step(1'b0, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0004, 5'b00111, 5'b11000, 4'b1111, 1'b0, 64'd21);
    // Stall with write stage flushed, then reset mid-stall
    step(1'b0, 5'b11111, 1'b1, 1'b0, 32'h0,         32'h0000_0004, 5'b01010, 5'b10100, 4'b1100, 1'b1, 64'd21);
    step(1'b1, 5'b11111, 1'b0, 1'b0, 32'h0,         32'h0000_0000, 5'b00001, 5'b11110, 4'b0000, 1'b0, 64'd0);
    // Fetch not done after reset: hold
    step(1'b0, 5'b00000, 1'b0, 1'b0, 32'h0,         32'h0000_0000, 5'b00000, 5'b11110, 4'b0000, 1'b0, 64'd0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() != 0) @(posedge clk);
    end
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expected states never checked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
